// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
// Data-memory bus between the MEM-stage controller and the data memory.
// Request channel (controller -> memory):
//   dmem_req    bus request, held until granted
//   dmem_we     1 = write, 0 = read
//   dmem_addr   word-aligned byte address
//   dmem_wdata  lane-replicated store data
//   dmem_be     byte enables
// Response channel (memory -> controller):
//   dmem_gnt    request accepted this cycle
//   dmem_rvalid read data valid this cycle
//   dmem_rdata  read data word
interface mem_access_ctrl_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_gnt, dmem_rvalid, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_gnt, dmem_rvalid, dmem_rdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// MEM-stage data-memory controller of the 5-stage RISC-V pipeline. Turns the
// EX/MEM load/store controls into one req/gnt/rvalid bus transaction, formats
// byte enables and store data, sign/zero-extends the load result for MEM/WB
// and stalls the front of the pipeline until the access has completed.
//
// Ports:
//   clk               pipeline clock
//   reset             synchronous active-low reset
//   memRead_EX_MEM    load in MEM stage
//   memWrite_EX_MEM   store in MEM stage (wins if both are set)
//   funct3_EX_MEM     access size / signedness
//   aluResult_EX_MEM  byte address
//   writeData_EX_MEM  store source (rs2)
//   data              extended load result to MEM/WB
//   stall_MEM         freeze front of pipe; MEM/WB takes a bubble while high
//   misaligned_MEM    misaligned access flag, valid in DONE
//   busErr_MEM        bus timeout flag, valid in DONE
//   bus               data-memory bus (master side)
//
// Optional feature macro: MEM_TIMEOUT_EN
//   defined   : a TO_W-bit counter aborts a transaction that spends
//               TIMEOUT_CYCLES cycles in REQ+WAIT_R, reporting busErr_MEM.
//   undefined : no counter, busErr_MEM is constant 0, the FSM waits forever.
module mem_access_ctrl #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_W           = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                memRead_EX_MEM,
   input  logic                memWrite_EX_MEM,
   input  logic [2:0]          funct3_EX_MEM,
   input  logic [31:0]         aluResult_EX_MEM,
   input  logic [31:0]         writeData_EX_MEM,
   output logic [31:0]         data,
   output logic                stall_MEM,
   output logic                misaligned_MEM,
   output logic                busErr_MEM,
   mem_access_ctrl_if.master   bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_WAIT_R = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_e;

   state_e      state_r;
   size_e       size_r;
   logic        uns_r;
   logic [1:0]  lo_r;

   logic        access_s;
   size_e       size_s;
   logic        misaligned_s;
   logic [3:0]  be_s;
   logic [31:0] wdata_s;

   // funct3[1:0]: 00 byte, 01 half, anything else (incl. reserved) word
   function automatic size_e decode_size(input logic [2:0] f3);
      size_e sz;
      case (f3[1:0])
         2'b00:   sz = SZ_B;
         2'b01:   sz = SZ_H;
         default: sz = SZ_W;
      endcase
      return sz;
   endfunction

   // Pick the addressed lane out of the read word and extend it
   function automatic logic [31:0] load_extend(input logic [31:0] rd,
                                               input logic [1:0]  lo,
                                               input size_e       sz,
                                               input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (lo)
         2'b00:   b = rd[7:0];
         2'b01:   b = rd[15:8];
         2'b10:   b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h = lo[1] ? rd[31:16] : rd[15:0];
      case (sz)
         SZ_B:    res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
         SZ_H:    res = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
         default: res = rd;
      endcase
      return res;
   endfunction

   // Request decode, alignment check and store formatting for the EX/MEM access
   always_comb begin
      access_s     = memRead_EX_MEM | memWrite_EX_MEM;
      size_s       = decode_size(funct3_EX_MEM);
      misaligned_s = 1'b0;
      be_s         = 4'b0000;
      wdata_s      = 32'h0000_0000;
      case (size_s)
         SZ_B: begin
            be_s    = 4'b0001 << aluResult_EX_MEM[1:0];
            wdata_s = {4{writeData_EX_MEM[7:0]}};
         end
         SZ_H: begin
            misaligned_s = aluResult_EX_MEM[0];
            be_s         = 4'b0011 << {aluResult_EX_MEM[1], 1'b0};
            wdata_s      = {2{writeData_EX_MEM[15:0]}};
         end
         default: begin
            misaligned_s = (aluResult_EX_MEM[1:0] != 2'b00);
            be_s         = 4'b1111;
            wdata_s      = writeData_EX_MEM;
         end
      endcase
      // Loads share the enable pattern but never drive store data
      if (!memWrite_EX_MEM) begin
         wdata_s = 32'h0000_0000;
      end else begin
         wdata_s = wdata_s;
      end
   end

   // Stall while an access is pending; DONE releases the pipe for one edge
   always_comb begin
      case (state_r)
         ST_IDLE:   stall_MEM = access_s;
         ST_REQ:    stall_MEM = 1'b1;
         ST_WAIT_R: stall_MEM = 1'b1;
         default:   stall_MEM = 1'b0;
      endcase
   end

`ifdef MEM_TIMEOUT_EN
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] to_cnt_r;
   // A transaction is aborted on the cycle the counter shows TIMEOUT_CYCLES-1,
   // i.e. after exactly TIMEOUT_CYCLES cycles in REQ+WAIT_R.
   logic            timeout_s;
   assign timeout_s = (to_cnt_r == TO_LIMIT);
`else
   assign busErr_MEM = 1'b0;
`endif

   // Transaction FSM with registered bus outputs and load result
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r           <= ST_IDLE;
         size_r            <= SZ_W;
         uns_r             <= 1'b0;
         lo_r              <= 2'b00;
         data              <= 32'h0000_0000;
         misaligned_MEM    <= 1'b0;
         bus.dmem_req      <= 1'b0;
         bus.dmem_we       <= 1'b0;
         bus.dmem_addr     <= 32'h0000_0000;
         bus.dmem_wdata    <= 32'h0000_0000;
         bus.dmem_be       <= 4'b0000;
`ifdef MEM_TIMEOUT_EN
         busErr_MEM        <= 1'b0;
         to_cnt_r          <= '0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (access_s && misaligned_s) begin
                  misaligned_MEM <= 1'b1;
                  state_r        <= ST_DONE;
               end else if (access_s) begin
                  bus.dmem_req   <= 1'b1;
                  bus.dmem_we    <= memWrite_EX_MEM;
                  bus.dmem_addr  <= {aluResult_EX_MEM[31:2], 2'b00};
                  bus.dmem_wdata <= wdata_s;
                  bus.dmem_be    <= be_s;
                  size_r         <= size_s;
                  uns_r          <= funct3_EX_MEM[2];
                  lo_r           <= aluResult_EX_MEM[1:0];
                  state_r        <= ST_REQ;
               end else begin
                  state_r        <= ST_IDLE;
               end
            end
            ST_REQ: begin
               // rvalid is deliberately not looked at here
               if (bus.dmem_gnt) begin
                  bus.dmem_req <= 1'b0;
                  state_r      <= bus.dmem_we ? ST_DONE : ST_WAIT_R;
`ifdef MEM_TIMEOUT_EN
               end else if (timeout_s) begin
                  bus.dmem_req <= 1'b0;
                  data         <= 32'h0000_0000;
                  busErr_MEM   <= 1'b1;
                  state_r      <= ST_DONE;
`endif
               end else begin
                  state_r      <= ST_REQ;
               end
            end
            ST_WAIT_R: begin
               if (bus.dmem_rvalid) begin
                  data    <= load_extend(bus.dmem_rdata, lo_r, size_r, uns_r);
                  state_r <= ST_DONE;
`ifdef MEM_TIMEOUT_EN
               end else if (timeout_s) begin
                  data       <= 32'h0000_0000;
                  busErr_MEM <= 1'b1;
                  state_r    <= ST_DONE;
`endif
               end else begin
                  state_r <= ST_WAIT_R;
               end
            end
            ST_DONE: begin
               misaligned_MEM <= 1'b0;
`ifdef MEM_TIMEOUT_EN
               busErr_MEM     <= 1'b0;
`endif
               state_r        <= ST_IDLE;
            end
            default: begin
               bus.dmem_req <= 1'b0;
               state_r      <= ST_IDLE;
            end
         endcase
`ifdef MEM_TIMEOUT_EN
         if ((state_r == ST_REQ) || (state_r == ST_WAIT_R)) begin
            to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
         end else begin
            to_cnt_r <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
   logic        clk;
   logic        reset;
   logic        memRead_EX_MEM;
   logic        memWrite_EX_MEM;
   logic [2:0]  funct3_EX_MEM;
   logic [31:0] aluResult_EX_MEM;
   logic [31:0] writeData_EX_MEM;
   logic [31:0] data;
   logic        stall_MEM;
   logic        misaligned_MEM;
   logic        busErr_MEM;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_data = 32'h0000_0000;

   mem_access_ctrl_if bus_if ();

   mem_access_ctrl #(
      .TIMEOUT_CYCLES (4),
      .TO_W           (8)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .memRead_EX_MEM   (memRead_EX_MEM),
      .memWrite_EX_MEM  (memWrite_EX_MEM),
      .funct3_EX_MEM    (funct3_EX_MEM),
      .aluResult_EX_MEM (aluResult_EX_MEM),
      .writeData_EX_MEM (writeData_EX_MEM),
      .data             (data),
      .stall_MEM        (stall_MEM),
      .misaligned_MEM   (misaligned_MEM),
      .busErr_MEM       (busErr_MEM),
      .bus              (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      memRead_EX_MEM = 1'b0; memWrite_EX_MEM = 1'b0;
      funct3_EX_MEM = 3'b000; aluResult_EX_MEM = 32'h0; writeData_EX_MEM = 32'h0;
      bus_if.dmem_gnt = 1'b0; bus_if.dmem_rvalid = 1'b0; bus_if.dmem_rdata = 32'h0;
      tick(); tick();
      reset = 1'b1;
      #1;
      total++; if (data !== 32'h0) begin $display("FAIL rst_data got=%h exp=%h", data, 32'h0); bad++; end
      total++; if (bus_if.dmem_req !== 1'b0) begin $display("FAIL rst_req got=%b exp=0", bus_if.dmem_req); bad++; end
      total++; if (bus_if.dmem_we !== 1'b0) begin $display("FAIL rst_we got=%b exp=0", bus_if.dmem_we); bad++; end
      total++; if (bus_if.dmem_addr !== 32'h0) begin $display("FAIL rst_addr got=%h exp=0", bus_if.dmem_addr); bad++; end
      total++; if (bus_if.dmem_wdata !== 32'h0) begin $display("FAIL rst_wdata got=%h exp=0", bus_if.dmem_wdata); bad++; end
      total++; if (bus_if.dmem_be !== 4'b0) begin $display("FAIL rst_be got=%b exp=0000", bus_if.dmem_be); bad++; end
      total++; if (misaligned_MEM !== 1'b0) begin $display("FAIL rst_mis got=%b exp=0", misaligned_MEM); bad++; end
      total++; if (busErr_MEM !== 1'b0) begin $display("FAIL rst_berr got=%b exp=0", busErr_MEM); bad++; end
      total++; if (stall_MEM !== 1'b0) begin $display("FAIL rst_stall got=%b exp=0", stall_MEM); bad++; end
      tick();
   endtask

   // Loads: address, funct3, read word, expected be, expected data, extra WAIT_R cycle
   task automatic test_loads();
      logic [31:0] va [6];
      logic [2:0]  vf [6];
      logic [31:0] vr [6];
      logic [3:0]  vb [6];
      logic [31:0] ve [6];
      logic        vl [6];
      int          nst;
      va[0] = 32'h0000_0103; vf[0] = 3'b000; vr[0] = 32'h80FF_1234; vb[0] = 4'b1000; ve[0] = 32'hFFFF_FF80; vl[0] = 1'b0;
      va[1] = 32'h0000_0202; vf[1] = 3'b101; vr[1] = 32'hBEEF_0000; vb[1] = 4'b1100; ve[1] = 32'h0000_BEEF; vl[1] = 1'b1;
      va[2] = 32'h0000_0202; vf[2] = 3'b001; vr[2] = 32'hBEEF_0000; vb[2] = 4'b1100; ve[2] = 32'hFFFF_BEEF; vl[2] = 1'b0;
      va[3] = 32'h0000_0408; vf[3] = 3'b010; vr[3] = 32'hCAFE_F00D; vb[3] = 4'b1111; ve[3] = 32'hCAFE_F00D; vl[3] = 1'b1;
      va[4] = 32'h0000_0101; vf[4] = 3'b100; vr[4] = 32'h80FF_1234; vb[4] = 4'b0010; ve[4] = 32'h0000_0012; vl[4] = 1'b0;
      va[5] = 32'h0000_0102; vf[5] = 3'b000; vr[5] = 32'h80FF_1234; vb[5] = 4'b0100; ve[5] = 32'hFFFF_FFFF; vl[5] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         nst = 0;
         memRead_EX_MEM = 1'b1; memWrite_EX_MEM = 1'b0;
         funct3_EX_MEM = vf[i]; aluResult_EX_MEM = va[i]; writeData_EX_MEM = 32'hFFFF_FFFF;
         #1;
         if (stall_MEM === 1'b1) nst++;
         total++; if (bus_if.dmem_req !== 1'b0) begin $display("FAIL ld%0d_idle_req got=%b exp=0", i, bus_if.dmem_req); bad++; end
         tick();
         if (stall_MEM === 1'b1) nst++;
         total++; if (bus_if.dmem_req !== 1'b1) begin $display("FAIL ld%0d_req got=%b exp=1", i, bus_if.dmem_req); bad++; end
         total++; if (bus_if.dmem_addr !== {va[i][31:2], 2'b00}) begin $display("FAIL ld%0d_addr got=%h exp=%h", i, bus_if.dmem_addr, {va[i][31:2], 2'b00}); bad++; end
         total++; if (bus_if.dmem_be !== vb[i]) begin $display("FAIL ld%0d_be got=%b exp=%b", i, bus_if.dmem_be, vb[i]); bad++; end
         total++; if (bus_if.dmem_we !== 1'b0) begin $display("FAIL ld%0d_we got=%b exp=0", i, bus_if.dmem_we); bad++; end
         total++; if (bus_if.dmem_wdata !== 32'h0) begin $display("FAIL ld%0d_wdata got=%h exp=0", i, bus_if.dmem_wdata); bad++; end
         bus_if.dmem_gnt = 1'b1;
         if (vl[i]) begin
            bus_if.dmem_rvalid = 1'b1; bus_if.dmem_rdata = 32'h7777_7777;
         end
         tick();
         bus_if.dmem_gnt = 1'b0; bus_if.dmem_rvalid = 1'b0; bus_if.dmem_rdata = 32'h0;
         if (stall_MEM === 1'b1) nst++;
         total++; if (bus_if.dmem_req !== 1'b0) begin $display("FAIL ld%0d_req_drop got=%b exp=0", i, bus_if.dmem_req); bad++; end
         total++; if (data !== exp_data) begin $display("FAIL ld%0d_data_wait got=%h exp=%h", i, data, exp_data); bad++; end
         if (vl[i]) begin
            tick();
            if (stall_MEM === 1'b1) nst++;
         end
         bus_if.dmem_rvalid = 1'b1; bus_if.dmem_rdata = vr[i];
         tick();
         bus_if.dmem_rvalid = 1'b0; bus_if.dmem_rdata = 32'h0;
         exp_data = ve[i];
         total++; if (data !== exp_data) begin $display("FAIL ld%0d_data got=%h exp=%h", i, data, exp_data); bad++; end
         total++; if (stall_MEM !== 1'b0) begin $display("FAIL ld%0d_done_stall got=%b exp=0", i, stall_MEM); bad++; end
         total++; if (nst !== (vl[i] ? 4 : 3)) begin $display("FAIL ld%0d_stall_cycles got=%0d exp=%0d", i, nst, (vl[i] ? 4 : 3)); bad++; end
         memRead_EX_MEM = 1'b0;
         tick();
         total++; if (stall_MEM !== 1'b0) begin $display("FAIL ld%0d_idle_stall got=%b exp=0", i, stall_MEM); bad++; end
      end
   endtask

   // Stores: address, funct3, rs2, expected be/wdata, grant delay, memRead also set
   task automatic test_stores();
      logic [31:0] va [3];
      logic [2:0]  vf [3];
      logic [31:0] vd [3];
      logic [3:0]  vb [3];
      logic [31:0] vw [3];
      int          vdl [3];
      logic        vboth [3];
      int          nst;
      va[0] = 32'h0000_0301; vf[0] = 3'b000; vd[0] = 32'h1234_56AB; vb[0] = 4'b0010; vw[0] = 32'hABAB_ABAB; vdl[0] = 3; vboth[0] = 1'b0;
      va[1] = 32'h0000_0302; vf[1] = 3'b001; vd[1] = 32'h1234_5678; vb[1] = 4'b1100; vw[1] = 32'h5678_5678; vdl[1] = 0; vboth[1] = 1'b0;
      va[2] = 32'h0000_0500; vf[2] = 3'b010; vd[2] = 32'hCAFE_BABE; vb[2] = 4'b1111; vw[2] = 32'hCAFE_BABE; vdl[2] = 1; vboth[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         nst = 0;
         memWrite_EX_MEM = 1'b1; memRead_EX_MEM = vboth[i];
         funct3_EX_MEM = vf[i]; aluResult_EX_MEM = va[i]; writeData_EX_MEM = vd[i];
         #1;
         if (stall_MEM === 1'b1) nst++;
         tick();
         for (int k = 0; k <= vdl[i]; k++) begin
            if (stall_MEM === 1'b1) nst++;
            total++; if (bus_if.dmem_req !== 1'b1) begin $display("FAIL st%0d_req c%0d got=%b exp=1", i, k, bus_if.dmem_req); bad++; end
            total++; if (bus_if.dmem_addr !== {va[i][31:2], 2'b00}) begin $display("FAIL st%0d_addr c%0d got=%h exp=%h", i, k, bus_if.dmem_addr, {va[i][31:2], 2'b00}); bad++; end
            total++; if (bus_if.dmem_be !== vb[i]) begin $display("FAIL st%0d_be c%0d got=%b exp=%b", i, k, bus_if.dmem_be, vb[i]); bad++; end
            total++; if (bus_if.dmem_wdata !== vw[i]) begin $display("FAIL st%0d_wdata c%0d got=%h exp=%h", i, k, bus_if.dmem_wdata, vw[i]); bad++; end
            total++; if (bus_if.dmem_we !== 1'b1) begin $display("FAIL st%0d_we c%0d got=%b exp=1", i, k, bus_if.dmem_we); bad++; end
            bus_if.dmem_gnt = (k == vdl[i]);
            bus_if.dmem_rvalid = 1'b1;
            tick();
         end
         bus_if.dmem_gnt = 1'b0; bus_if.dmem_rvalid = 1'b0;
         if (stall_MEM === 1'b1) nst++;
         total++; if (bus_if.dmem_req !== 1'b0) begin $display("FAIL st%0d_done_req got=%b exp=0", i, bus_if.dmem_req); bad++; end
         total++; if (stall_MEM !== 1'b0) begin $display("FAIL st%0d_done_stall got=%b exp=0", i, stall_MEM); bad++; end
         total++; if (nst !== vdl[i] + 2) begin $display("FAIL st%0d_stall_cycles got=%0d exp=%0d", i, nst, vdl[i] + 2); bad++; end
         total++; if (data !== exp_data) begin $display("FAIL st%0d_data got=%h exp=%h", i, data, exp_data); bad++; end
         memWrite_EX_MEM = 1'b0; memRead_EX_MEM = 1'b0;
         tick();
      end
   endtask

   task automatic test_misaligned();
      logic [31:0] va [2];
      logic [2:0]  vf [2];
      logic        vw [2];
      va[0] = 32'h0000_0402; vf[0] = 3'b010; vw[0] = 1'b0;
      va[1] = 32'h0000_0301; vf[1] = 3'b001; vw[1] = 1'b1;
      for (int i = 0; i < 2; i++) begin
         memRead_EX_MEM = ~vw[i]; memWrite_EX_MEM = vw[i];
         funct3_EX_MEM = vf[i]; aluResult_EX_MEM = va[i]; writeData_EX_MEM = 32'h5555_5555;
         #1;
         total++; if (stall_MEM !== 1'b1) begin $display("FAIL mis%0d_idle_stall got=%b exp=1", i, stall_MEM); bad++; end
         tick();
         total++; if (misaligned_MEM !== 1'b1) begin $display("FAIL mis%0d_flag got=%b exp=1", i, misaligned_MEM); bad++; end
         total++; if (bus_if.dmem_req !== 1'b0) begin $display("FAIL mis%0d_req got=%b exp=0", i, bus_if.dmem_req); bad++; end
         total++; if (stall_MEM !== 1'b0) begin $display("FAIL mis%0d_done_stall got=%b exp=0", i, stall_MEM); bad++; end
         total++; if (data !== exp_data) begin $display("FAIL mis%0d_data got=%h exp=%h", i, data, exp_data); bad++; end
         memRead_EX_MEM = 1'b0; memWrite_EX_MEM = 1'b0;
         tick();
         total++; if (misaligned_MEM !== 1'b0) begin $display("FAIL mis%0d_clear got=%b exp=0", i, misaligned_MEM); bad++; end
      end
   endtask

   task automatic test_ignore_idle();
      bus_if.dmem_gnt = 1'b1; bus_if.dmem_rvalid = 1'b1; bus_if.dmem_rdata = 32'h1357_9BDF;
      tick(); tick();
      bus_if.dmem_gnt = 1'b0; bus_if.dmem_rvalid = 1'b0; bus_if.dmem_rdata = 32'h0;
      total++; if (data !== exp_data) begin $display("FAIL idle_resp_data got=%h exp=%h", data, exp_data); bad++; end
      total++; if (bus_if.dmem_req !== 1'b0) begin $display("FAIL idle_resp_req got=%b exp=0", bus_if.dmem_req); bad++; end
      total++; if (stall_MEM !== 1'b0) begin $display("FAIL idle_resp_stall got=%b exp=0", stall_MEM); bad++; end
   endtask

   task automatic test_reset_mid();
      memRead_EX_MEM = 1'b1; funct3_EX_MEM = 3'b010; aluResult_EX_MEM = 32'h0000_0600;
      tick();
      bus_if.dmem_gnt = 1'b1;
      tick();
      bus_if.dmem_gnt = 1'b0;
      total++; if (stall_MEM !== 1'b1) begin $display("FAIL rmid_wait_stall got=%b exp=1", stall_MEM); bad++; end
      reset = 1'b0;
      memRead_EX_MEM = 1'b0;
      tick();
      exp_data = 32'h0;
      total++; if (data !== 32'h0) begin $display("FAIL rmid_data got=%h exp=0", data); bad++; end
      total++; if (bus_if.dmem_req !== 1'b0) begin $display("FAIL rmid_req got=%b exp=0", bus_if.dmem_req); bad++; end
      total++; if (bus_if.dmem_addr !== 32'h0) begin $display("FAIL rmid_addr got=%h exp=0", bus_if.dmem_addr); bad++; end
      total++; if (bus_if.dmem_be !== 4'b0) begin $display("FAIL rmid_be got=%b exp=0000", bus_if.dmem_be); bad++; end
      total++; if (stall_MEM !== 1'b0) begin $display("FAIL rmid_stall got=%b exp=0", stall_MEM); bad++; end
      reset = 1'b1;
      tick();
      bus_if.dmem_rvalid = 1'b1; bus_if.dmem_rdata = 32'hA5A5_A5A5;
      tick();
      bus_if.dmem_rvalid = 1'b0; bus_if.dmem_rdata = 32'h0;
      tick();
      total++; if (data !== 32'h0) begin $display("FAIL rmid_late_data got=%h exp=0", data); bad++; end
      total++; if (stall_MEM !== 1'b0) begin $display("FAIL rmid_late_stall got=%b exp=0", stall_MEM); bad++; end
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout();
      memWrite_EX_MEM = 1'b1; funct3_EX_MEM = 3'b010;
      aluResult_EX_MEM = 32'h0000_0700; writeData_EX_MEM = 32'h0BAD_F00D;
      tick();
      for (int k = 0; k < 4; k++) begin
         total++; if (bus_if.dmem_req !== 1'b1) begin $display("FAIL to_req c%0d got=%b exp=1", k, bus_if.dmem_req); bad++; end
         tick();
      end
      exp_data = 32'h0;
      total++; if (bus_if.dmem_req !== 1'b0) begin $display("FAIL to_req_drop got=%b exp=0", bus_if.dmem_req); bad++; end
      total++; if (busErr_MEM !== 1'b1) begin $display("FAIL to_berr got=%b exp=1", busErr_MEM); bad++; end
      total++; if (stall_MEM !== 1'b0) begin $display("FAIL to_stall got=%b exp=0", stall_MEM); bad++; end
      total++; if (data !== 32'h0) begin $display("FAIL to_data got=%h exp=0", data); bad++; end
      memWrite_EX_MEM = 1'b0;
      tick();
      total++; if (busErr_MEM !== 1'b0) begin $display("FAIL to_berr_clear got=%b exp=0", busErr_MEM); bad++; end
      total++; if (bus_if.dmem_req !== 1'b0) begin $display("FAIL to_idle_req got=%b exp=0", bus_if.dmem_req); bad++; end
   endtask
`endif

   initial begin
      test_reset();
      test_loads();
      test_stores();
      test_misaligned();
      test_ignore_idle();
      test_reset_mid();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
